ipv6_header_sequencer: RTL and testbench
========================================

Name: ipv6_header_sequencer

Overview:
- Controller that assembles one package_ipv6::t_ipv6_header (320 bits) from ten consecutive 32-bit package_arrays::t_data32 beats on a valid/ready stream.
- Sequences the word counter, detects packet start, presents the finished header on a valid/ready output and flags a version mismatch.
- Sits between the 32-bit ingress bus and header-processing logic.
- Counts discarded or aborted beats.

Parameters:
- VERSION, 4'd6, expected Version field value.
- CHECK_VERSION, 1, 1 = drive o_err from the version compare; 0 = o_err tied 0.
- CNT_W, 16, width of the o_drops counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  input beat valid.
- i_ready  output  1  input beat accepted when i_valid && i_ready.
- i_sop  input  1  beat is word 0 of a header.
- i_data  input  t_data32 (32)  input word.
- o_valid  output  1  o_head complete and stable.
- o_ready  input  1  downstream accepts the header.
- o_head  output  t_ipv6_header (320)  assembled header.
- o_err  output  1  valid with o_valid: o_head.Version != VERSION.
- o_drops  output  CNT_W  saturating count of dropped beats/headers.

Behaviour:
- Reset values: state IDLE, word counter cnt=0, i_ready=1, o_valid=0, o_err=0, o_head='0, o_drops=0.
- Word order is network order. Accepted beat k (0..9) is written to o_head[319-32k -: 32], so beat 0 carries Version/TrafficClass/FlowLabel. Only the addressed slice is written.
- FSM states: IDLE, COLLECT, HOLD.
- IDLE:
  - i_ready=1.
  - Accepted beat with i_sop=1: write slice 0, set cnt=1, go to COLLECT.
  - Accepted beat with i_sop=0: discard the beat, o_drops+1.
- COLLECT:
  - i_ready=1.
  - Accepted beat with i_sop=0: write slice cnt, then cnt+1.
  - Accepted beat with i_sop=1: abort the partial header, o_drops+1, write slice 0, set cnt=1, stay in COLLECT. Stale slices are overwritten by later beats.
  - When the accepted beat has cnt==9: cnt wraps to 0, go to HOLD, assert o_valid on the next cycle.
  - Latency: o_valid rises 1 cycle after the 10th accepted beat.
- HOLD:
  - o_valid=1; o_head and o_err are stable until the handshake.
  - i_ready=0 (base build). o_valid does not depend on o_ready.
  - On o_valid && o_ready: o_valid=0, go to IDLE next cycle.
- o_err = CHECK_VERSION && (o_head[319:316] != VERSION). It is combinational from the registered o_head and qualified by o_valid.
- o_drops saturates at all-ones and does not wrap.
- i_valid gaps of any length inside COLLECT are legal; cnt holds.
- rst asserted mid-COLLECT or mid-HOLD: the partial or held header is discarded and all reset values are restored next cycle. o_drops also resets.

Optional Feature:
- Macro: IPV6_SEQ_CUTTHRU_EN.
- Defined: in HOLD, i_ready = o_ready. A beat with i_sop=1 accepted in the same cycle as the output handshake writes slice 0, sets cnt=1 and goes directly to COLLECT. Same-cycle beat with i_sop=0 is dropped and o_drops+1. Back-to-back headers therefore need 10 cycles each.
- Not defined: i_ready=0 in HOLD, with one mandatory IDLE-or-later cycle between headers, so back-to-back headers need 11 cycles each.

Test Plan:
- Reset, then 10 beats with sop on beat 0, beat 0=32'h6000_0000, others 32'h0000_0001..9, o_ready=1 -> o_valid 1 cycle after beat 9; o_head[319:288]=32'h6000_0000; o_head[31:0]=32'h0000_0009; o_err=0; o_drops=0.
- Same stream but beat 0=32'h4000_0000 -> o_err=1 while o_valid=1. Rebuild with CHECK_VERSION=0 -> o_err=0.
- 3 beats without sop in IDLE -> all accepted (i_ready=1), no o_valid, o_drops=3.
- sop on beat 0, 4 beats, new sop, then 9 more beats -> one header containing only the second packet's words; o_drops=1.
- Header complete, o_ready=0 for 5 cycles -> o_valid and o_head stable and i_ready=0 throughout. Then o_ready=1 -> o_valid drops the next cycle. Without the macro, next sop is accepted no earlier than the following cycle; with IPV6_SEQ_CUTTHRU_EN, a sop on the handshake cycle is accepted.
- rst pulsed after 6 beats -> o_valid=0, cnt=0 and o_drops=0 next cycle; a following full 10-beat header assembles correctly.

Source files
------------

// File: rtl/ipv6_header_sequencer_if.sv
// Stream bundle between the 32-bit ingress bus, the header sequencer and the
// header-processing logic downstream.
//   i_valid/i_ready/i_sop/i_data : ingress beat stream (master drives valid/sop/data)
//   o_valid/o_ready/o_head/o_err : assembled 320-bit header stream (slave drives valid/head/err)
// Modports: master = stream source and header sink, slave = the sequencer.
interface ipv6_header_sequencer_if;
    logic         i_valid;
    logic         i_ready;
    logic         i_sop;
    logic [31:0]  i_data;
    logic         o_valid;
    logic         o_ready;
    logic [319:0] o_head;
    logic         o_err;

    modport master (
        output i_valid, i_sop, i_data, o_ready,
        input  i_ready, o_valid, o_head, o_err
    );

    modport slave (
        input  i_valid, i_sop, i_data, o_ready,
        output i_ready, o_valid, o_head, o_err
    );
endinterface

// File: rtl/ipv6_header_sequencer.sv
// Assembles one 320-bit IPv6 header from ten 32-bit network-order beats,
// presents it on a valid/ready output and flags a Version mismatch.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : ipv6_header_sequencer_if.slave (ingress beats in, header out)
//   o_drops : saturating count of discarded beats and aborted headers
// Optional feature: define IPV6_SEQ_CUTTHRU_EN to accept a new beat in the
// same cycle as the output handshake (10 cycles per back-to-back header
// instead of 11).
module ipv6_header_sequencer #(
    parameter logic [3:0]  VERSION       = 4'd6,
    parameter bit          CHECK_VERSION = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ipv6_header_sequencer_if.slave bus,
    output logic [CNT_W-1:0]     o_drops
);

    localparam int unsigned WORDS = 10;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       cnt;
    logic [WORDS-1:0][31:0] words;
    logic                   o_valid_q;
    logic                   i_ready_c;
    logic                   accept_c;
    logic                   drop_c;

    // Input ready follows the state; in HOLD it optionally tracks o_ready.
    always_comb begin
        i_ready_c = 1'b1;
        if (state == HOLD) begin
`ifdef IPV6_SEQ_CUTTHRU_EN
            i_ready_c = bus.o_ready;
`else
            i_ready_c = 1'b0;
`endif
        end
    end

    assign accept_c = bus.i_valid && i_ready_c;

    // A beat is dropped when it cannot start or continue a header.
    always_comb begin
        drop_c = 1'b0;
        if (accept_c) begin
            case (state)
                IDLE:    drop_c = !bus.i_sop;
                COLLECT: drop_c = bus.i_sop;
                HOLD:    drop_c = !bus.i_sop;
                default: drop_c = 1'b0;
            endcase
        end
    end

    // Header sequencing FSM; words[9] is beat 0 (o_head[319:288]).
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            o_valid_q <= 1'b0;
            words     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c && bus.i_sop) begin
                        words[WORDS-1] <= bus.i_data;
                        cnt            <= IDX_W'(1);
                        state          <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept_c) begin
                        if (bus.i_sop) begin
                            // Restart: stale slices get overwritten by later beats.
                            words[WORDS-1] <= bus.i_data;
                            cnt            <= IDX_W'(1);
                        end else begin
                            words[IDX_W'(WORDS-1) - cnt] <= bus.i_data;
                            if (cnt == IDX_W'(WORDS-1)) begin
                                cnt       <= '0;
                                state     <= HOLD;
                                o_valid_q <= 1'b1;
                            end else begin
                                cnt <= cnt + IDX_W'(1);
                            end
                        end
                    end
                end
                HOLD: begin
                    if (bus.o_ready) begin
                        o_valid_q <= 1'b0;
                        state     <= IDLE;
                        // Only reachable when ready is passed through in HOLD.
                        if (accept_c && bus.i_sop) begin
                            words[WORDS-1] <= bus.i_data;
                            cnt            <= IDX_W'(1);
                            state          <= COLLECT;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    o_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_drops <= '0;
        end else if (drop_c && (o_drops != {CNT_W{1'b1}})) begin
            o_drops <= o_drops + CNT_W'(1);
        end
    end

    assign bus.i_ready = i_ready_c;
    assign bus.o_valid = o_valid_q;
    assign bus.o_head  = words;
    assign bus.o_err   = CHECK_VERSION && o_valid_q && (words[WORDS-1][31:28] != VERSION);

endmodule

// File: tb/tb_ipv6_header_sequencer.sv
module tb_ipv6_header_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [319:0] exp_q [$];
    logic         err_q [$];

    ipv6_header_sequencer_if ifc0 ();
    ipv6_header_sequencer_if ifc1 ();

    logic [15:0] drops0;
    logic [1:0]  drops1;

    ipv6_header_sequencer #(.VERSION(4'd6), .CHECK_VERSION(1'b1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .bus(ifc0.slave), .o_drops(drops0)
    );

    ipv6_header_sequencer #(.VERSION(4'd6), .CHECK_VERSION(1'b0), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .bus(ifc1.slave), .o_drops(drops1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic sop, input logic [31:0] d);
        ifc0.i_valid = v; ifc0.i_sop = sop; ifc0.i_data = d;
        ifc1.i_valid = v; ifc1.i_sop = sop; ifc1.i_data = d;
    endtask

    task automatic set_ready(input logic r);
        ifc0.o_ready = r;
        ifc1.o_ready = r;
    endtask

    // One accepted beat; returns just after the accepting edge.
    task automatic beat(input logic sop, input logic [31:0] d);
        int n = 0;
        drive(1'b1, sop, d);
        @(negedge clk);
        while (!ifc0.i_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("beat_accept_timeout", 320'(ifc0.i_ready), 320'(1));
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full header: w0 then 1..9, optional gap after beat 'gap_at'.
    task automatic send_header(input logic [31:0] w0, input int gap_at, input logic push);
        logic [319:0] e;
        e = '0;
        e[319 -: 32] = w0;
        for (int k = 1; k < 10; k++) e[319 - 32*k -: 32] = 32'(k);
        if (push) begin
            exp_q.push_back(e);
            err_q.push_back(w0[31:28] != 4'd6);
        end
        beat(1'b1, w0);
        for (int k = 1; k < 10; k++) begin
            if (k == gap_at) idle(3);
            beat(1'b0, 32'(k));
        end
    endtask

    // Scoreboard: compare every header handed downstream.
    always @(negedge clk) begin
        if (!rst && ifc0.o_valid && ifc0.o_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_header", ifc0.o_head, '0);
            end else begin
                check("head", ifc0.o_head, exp_q.pop_front());
                check("err", 320'(ifc0.o_err), 320'(err_q.pop_front()));
                check("nocheck_valid", 320'(ifc1.o_valid), 320'(1));
                check("nocheck_err", 320'(ifc1.o_err), 320'(0));
            end
        end
    end

    initial begin
        logic [319:0] held;
        int n;
        drive(1'b0, 1'b0, 32'h0);
        set_ready(1'b1);
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_o_valid", 320'(ifc0.o_valid), 320'(0));
        check("rst_i_ready", 320'(ifc0.i_ready), 320'(1));
        check("rst_o_err", 320'(ifc0.o_err), 320'(0));
        check("rst_o_head", ifc0.o_head, '0);
        check("rst_drops", 320'(drops0), 320'(0));
        idle(1);

        // Basic header, o_valid one cycle after beat 9
        send_header(32'h6000_0000, 0, 1'b1);
        @(negedge clk);
        check("lat_o_valid", 320'(ifc0.o_valid), 320'(1));
        check("head_hi", 320'(ifc0.o_head[319:288]), 320'(32'h6000_0000));
        check("head_lo", 320'(ifc0.o_head[31:0]), 320'(32'h0000_0009));
        check("drops_basic", 320'(drops0), 320'(0));
        idle(1);
        @(negedge clk);
        check("valid_dropped", 320'(ifc0.o_valid), 320'(0));
        idle(1);

        // Version mismatch
        send_header(32'h4000_0000, 0, 1'b1);
        @(negedge clk);
        check("err_set", 320'(ifc0.o_err), 320'(1));
        idle(2);

        // Non-sop beats in IDLE are dropped
        for (int k = 0; k < 3; k++) beat(1'b0, 32'hdead_0000 + 32'(k));
        @(negedge clk);
        check("idle_drop_valid", 320'(ifc0.o_valid), 320'(0));
        check("idle_drops", 320'(drops0), 320'(3));
        idle(1);

        // Abort after 4 beats, second packet assembled
        beat(1'b1, 32'h6111_1111);
        for (int k = 0; k < 3; k++) beat(1'b0, 32'hbad0_0000 + 32'(k));
        send_header(32'h6abc_0000, 0, 1'b1);
        @(negedge clk);
        check("abort_drops", 320'(drops0), 320'(4));
        check("sat_drops", 320'(drops1), 320'(3));
        idle(2);

        // Back-pressure with a gap mid-header
        set_ready(1'b0);
        send_header(32'h6555_0000, 4, 1'b1);
        held = '0;
        held[319 -: 32] = 32'h6555_0000;
        for (int k = 1; k < 10; k++) held[319 - 32*k -: 32] = 32'(k);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_valid", 320'(ifc0.o_valid), 320'(1));
            check("hold_head", ifc0.o_head, held);
            check("hold_i_ready", 320'(ifc0.i_ready), 320'(0));
        end
        @(posedge clk);
        #1;
        set_ready(1'b1);
        @(negedge clk);
`ifdef IPV6_SEQ_CUTTHRU_EN
        check("hs_i_ready", 320'(ifc0.i_ready), 320'(1));
`else
        check("hs_i_ready", 320'(ifc0.i_ready), 320'(0));
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_hs_valid", 320'(ifc0.o_valid), 320'(0));
        check("after_hs_i_ready", 320'(ifc0.i_ready), 320'(1));
        idle(1);

        // Reset mid-collect
        beat(1'b1, 32'h6777_0000);
        for (int k = 1; k < 6; k++) beat(1'b0, 32'(k));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 320'(ifc0.o_valid), 320'(0));
        check("rst_mid_drops", 320'(drops0), 320'(0));
        check("rst_mid_head", ifc0.o_head, '0);
        idle(1);
        send_header(32'h6999_0000, 0, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        check("scoreboard_empty", 320'(exp_q.size()), 320'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
